// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
// Shared definitions for the decode/operand-fetch stage and the execute stage
// that consumes its output register.
//   OF_DATA_WIDTH    : operand / data width
//   OF_ADDRESS_WIDTH : architectural register index width
//   id_ex_t          : ID/EX pipeline register payload
package operand_fetch_pkg;

    localparam int OF_DATA_WIDTH    = 32;
    localparam int OF_ADDRESS_WIDTH = 5;

    typedef struct packed {
        logic [OF_ADDRESS_WIDTH-1:0] rd;
        logic                        wb_en;
        logic                        is_load;
        logic [OF_DATA_WIDTH-1:0]    pc;
        logic [OF_DATA_WIDTH-1:0]    imm;
        logic [OF_DATA_WIDTH-1:0]    rs1_val;
        logic [OF_DATA_WIDTH-1:0]    rs2_val;
    } id_ex_t;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// operand_fetch_fwd_mux
// Combinational operand selector for one source register.
// Priority: x0 -> 0, EX result (non-load only), MEM result, register file.
// Ports:
//   rs                                    : source register index
//   rf_data                               : register file read data
//   ex_valid, ex_is_load, ex_rd, ex_data  : EX-stage forwarding source
//   mem_valid, mem_rd, mem_data           : MEM-stage forwarding source
//   val                                   : resolved operand
module operand_fetch_fwd_mux #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    input  logic                     ex_valid,
    input  logic                     ex_is_load,
    input  logic [ADDRESS_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]    ex_data,
    input  logic                     mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic [DATA_WIDTH-1:0]    val
);

    always_comb begin
        val = rf_data;
        if (rs == '0) begin
            // x0 is hardwired; forwarding a write to x0 must never leak through.
            val = '0;
        end else if (ex_valid && !ex_is_load && (ex_rd == rs)) begin
            // A load in EX has no data yet; that case is a load-use stall.
            val = ex_data;
        end else if (mem_valid && (mem_rd == rs)) begin
            val = mem_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
// Decode/operand-fetch stage: drives the register file read ports, resolves
// RAW hazards by forwarding from EX/MEM, stalls on load-use and registers the
// resolved instruction into the ID/EX pipeline register.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_*                            : decoded instruction (valid/ready)
//   rf_rd_addr1/2, rf_rd_data1/2    : register file read ports
//   ex_fwd_*, mem_fwd_*             : forwarding sources
//   flush                           : kill capture and held output
//   out_*                           : ID/EX register (valid/ready)
//   stall_count                     : saturating load-use stall cycle count
//
// Handshake: a transfer happens on a posedge where valid && ready. The
// producer holds valid and payload stable until that transfer; ready may
// depend combinationally on valid, never the other way round. in_ready here
// depends on in_valid (through load_use) and out_ready.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH      = OF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = OF_ADDRESS_WIDTH,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDRESS_WIDTH-1:0]   in_rs1,
    input  logic [ADDRESS_WIDTH-1:0]   in_rs2,
    input  logic [ADDRESS_WIDTH-1:0]   in_rd,
    input  logic                       in_use_rs1,
    input  logic                       in_use_rs2,
    input  logic                       in_wb_en,
    input  logic                       in_is_load,
    input  logic [DATA_WIDTH-1:0]      in_pc,
    input  logic [DATA_WIDTH-1:0]      in_imm,
    output logic [ADDRESS_WIDTH-1:0]   rf_rd_addr1,
    output logic [ADDRESS_WIDTH-1:0]   rf_rd_addr2,
    input  logic [DATA_WIDTH-1:0]      rf_rd_data1,
    input  logic [DATA_WIDTH-1:0]      rf_rd_data2,
    input  logic                       ex_fwd_valid,
    input  logic                       ex_fwd_is_load,
    input  logic [ADDRESS_WIDTH-1:0]   ex_fwd_rd,
    input  logic [DATA_WIDTH-1:0]      ex_fwd_data,
    input  logic                       mem_fwd_valid,
    input  logic [ADDRESS_WIDTH-1:0]   mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0]      mem_fwd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_rs1_val,
    output logic [DATA_WIDTH-1:0]      out_rs2_val,
    output logic [ADDRESS_WIDTH-1:0]   out_rd,
    output logic                       out_wb_en,
    output logic                       out_is_load,
    output logic [DATA_WIDTH-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]      out_imm,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    logic [DATA_WIDTH-1:0]      rs1_val;
    logic [DATA_WIDTH-1:0]      rs2_val;
    logic                       load_use;
    logic                       capture;
    id_ex_t                     payload_q;
    logic                       out_valid_q;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q;

    // Register file writes on negedge, so a same-cycle WB is already visible.
    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;

    operand_fetch_fwd_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_fwd_rs1 (
        .rs        (in_rs1),
        .rf_data   (rf_rd_data1),
        .ex_valid  (ex_fwd_valid),
        .ex_is_load(ex_fwd_is_load),
        .ex_rd     (ex_fwd_rd),
        .ex_data   (ex_fwd_data),
        .mem_valid (mem_fwd_valid),
        .mem_rd    (mem_fwd_rd),
        .mem_data  (mem_fwd_data),
        .val       (rs1_val)
    );

    operand_fetch_fwd_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_fwd_rs2 (
        .rs        (in_rs2),
        .rf_data   (rf_rd_data2),
        .ex_valid  (ex_fwd_valid),
        .ex_is_load(ex_fwd_is_load),
        .ex_rd     (ex_fwd_rd),
        .ex_data   (ex_fwd_data),
        .mem_valid (mem_fwd_valid),
        .mem_rd    (mem_fwd_rd),
        .mem_data  (mem_fwd_data),
        .val       (rs2_val)
    );

    // A load in EX whose rd is actually read by this instruction: its data only
    // appears on the MEM path next cycle, so hold the instruction one cycle.
    assign load_use = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                      ((in_use_rs1 && (in_rs1 == ex_fwd_rd)) ||
                       (in_use_rs2 && (in_rs2 == ex_fwd_rd)));

    assign in_ready = !load_use && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            payload_q     <= '0;
            out_valid_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            // Data may load during a flush; it is don't-care while out_valid=0.
            if (capture) begin
                payload_q.rd      <= in_rd;
                payload_q.wb_en   <= in_wb_en;
                payload_q.is_load <= in_is_load;
                payload_q.pc      <= in_pc;
                payload_q.imm     <= in_imm;
                payload_q.rs1_val <= rs1_val;
                payload_q.rs2_val <= rs2_val;
            end

            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (capture) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (load_use && !flush && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rd      = payload_q.rd;
    assign out_wb_en   = payload_q.wb_en;
    assign out_is_load = payload_q.is_load;
    assign out_pc      = payload_q.pc;
    assign out_imm     = payload_q.imm;
    assign out_rs1_val = payload_q.rs1_val;
    assign out_rs2_val = payload_q.rs2_val;
    assign stall_count = stall_count_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage of the RISC-V pipeline; sits directly upstream of the register file's read ports.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Resolves RAW hazards by forwarding from EX and MEM, and stalls on load-use.
- Registers resolved operands into the ID/EX pipeline register for the execute stage.

Parameters:
DATA_WIDTH, 32, operand/data width
ADDRESS_WIDTH, 5, register index width (32 architectural registers)
STALL_CNT_WIDTH, 16, width of the saturating load-use stall counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_rs1, in_rs2, in_rd  input  ADDRESS_WIDTH each  source/destination indices
in_use_rs1, in_use_rs2  input  1 each  instruction reads rs1/rs2
in_wb_en, in_is_load  input  1 each  writes rd / is a load
in_pc, in_imm  input  DATA_WIDTH each  pass-through fields
rf_rd_addr1, rf_rd_addr2  output  ADDRESS_WIDTH  register file read addresses
rf_rd_data1, rf_rd_data2  input  DATA_WIDTH  register file read data (combinational)
ex_fwd_valid, ex_fwd_is_load  input  1 each  EX holds a writing instr / it is a load
ex_fwd_rd  input  ADDRESS_WIDTH; ex_fwd_data  input  DATA_WIDTH  EX result
mem_fwd_valid  input  1; mem_fwd_rd  input  ADDRESS_WIDTH; mem_fwd_data  input  DATA_WIDTH  MEM result (load data valid here)
flush  input  1  kill the instruction being captured and the held output
out_valid  output  1; out_ready  input  1  ID/EX handshake
out_rs1_val, out_rs2_val  output  DATA_WIDTH  resolved operands
out_rd, out_wb_en, out_is_load, out_pc, out_imm  output  registered pass-through fields
stall_count  output  STALL_CNT_WIDTH  load-use stall cycles, saturating

Behaviour:
- Reset: on a rst posedge, all outputs and registers are 0: out_valid=0, operands 0, stall_count=0. rst overrides flush and capture.
- rf_rd_addr1/2 = in_rs1/in_rs2, combinational. The register file writes on negedge, so a WB write is visible in the same cycle; no WB forwarding path is needed.
- Operand select per source, in priority order:
  - index 0 -> 0.
  - ex_fwd_valid & ex_fwd_rd==rs & !ex_fwd_is_load -> ex_fwd_data.
  - mem_fwd_valid & mem_fwd_rd==rs -> mem_fwd_data.
  - else rf_rd_data.
- load_use = in_valid & ex_fwd_valid & ex_fwd_is_load & ex_fwd_rd!=0 & ((in_use_rs1 & in_rs1==ex_fwd_rd) | (in_use_rs2 & in_rs2==ex_fwd_rd)). Unused sources never cause a stall.
- in_ready = !load_use & (!out_valid | out_ready), combinational.
- Capture when in_valid & in_ready: the output register loads the operands and fields, and out_valid=1 next cycle.
- out_valid & out_ready with no capture: out_valid=0 next cycle.
- out_valid & !out_ready: all outputs hold and are stable.
- flush=1: out_valid=0 next cycle regardless of capture or out_ready. Data registers may update, but are don't-care while out_valid=0.
- Stall counter: stall_count increments on each posedge where load_use=1 and flush=0. It saturates at all-ones and never wraps.
- Latency: 1 cycle from accepted input to out_valid. Throughput is 1 per cycle with no stalls.

Decomposition:
- Shared package holds DATA_WIDTH, ADDRESS_WIDTH and a packed typedef for the ID/EX payload (rd, wb_en, is_load, pc, imm, rs1_val, rs2_val), reused by the execute stage.
- One sub-module, fwd_mux: a combinational per-source priority selector, instantiated twice.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, stall_count=0, in_ready=1 after release with out_ready=1.
- x0 guard: in_rs1=0, ex_fwd rd=0 data=0xDEADBEEF, valid=1 -> out_rs1_val=0.
- Forward priority: x5=0x33 in regfile, mem rd=5 data=0x22, ex rd=5 data=0x11 non-load, in_rs2=5 -> out_rs2_val=0x11. With EX removed -> 0x22. With MEM also removed -> 0x33.
- Load-use: ex load rd=7, in_rs2=7, use_rs2=1 -> in_ready=0 for 1 cycle, stall_count=1. Next cycle mem rd=7 data=0x44 -> captured out_rs2_val=0x44. With use_rs2=0 -> no stall.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> outputs unchanged, in_ready=0. Release -> next instruction captured the next cycle.
- Flush: flush=1 in the same cycle as a capture -> out_valid=0 next cycle. stall_count forced to all-ones with a further stall -> stays all-ones.
